// File: rtl/water_heater_controller.sv
// Wash-water heater controller: latches a target temperature on start, heats until the
// sensor settles at or above it, then holds with hysteresis. A heating timeout is a sticky fault.
module water_heater_controller #(
    parameter int TEMP_W         = 6,
    parameter int HYST           = 2,
    parameter int SETTLE_SAMPLES = 4,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TEMP_W-1:0] selected_temperature,
    input  logic [TEMP_W-1:0] water_temp,
    input  logic              temp_valid,
    output logic              heater_on,
    output logic              temp_reached,
    output logic              heat_fault,
    output logic              busy
);

    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_SAMPLES + 1);

    localparam logic [TEMP_W:0]     HYST_EXT    = (TEMP_W + 1)'(HYST);
    localparam logic [TIMER_W-1:0]  TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SETTLE_SAMPLES);

    typedef enum logic [1:0] {IDLE, HEAT, HOLD, FAULT} state_t;

    state_t              state;
    logic [TEMP_W-1:0]   target_q;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [TIMER_W-1:0]  timer;

    logic                at_target;
    logic                below_band;
    logic [SETTLE_W-1:0] settle_next;
    logic [TIMER_W-1:0]  timer_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        at_target   = 1'b0;
        below_band  = 1'b0;
        settle_next = settle_cnt;
        timer_next  = timer;

        at_target = (water_temp >= target_q);
        // One extra bit keeps water_temp + HYST from wrapping near the top of the range.
        below_band = (({1'b0, water_temp} + HYST_EXT) < {1'b0, target_q});

        if (temp_valid) begin
            settle_next = at_target ? settle_cnt + 1'b1 : '0;
        end

        if (timer != TIMER_LIMIT) begin
            timer_next = timer + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state        <= IDLE;
            target_q     <= '0;
            settle_cnt   <= '0;
            timer        <= '0;
            heater_on    <= 1'b0;
            temp_reached <= 1'b0;
            heat_fault   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        target_q   <= selected_temperature;
                        settle_cnt <= '0;
                        timer      <= '0;
                        busy       <= 1'b1;
                        if (selected_temperature == '0) begin
                            state        <= HOLD;
                            temp_reached <= 1'b1;
                            heater_on    <= 1'b0;
                        end else begin
                            state     <= HEAT;
                            heater_on <= 1'b1;
                        end
                    end
                end

                HEAT: begin
                    timer      <= timer_next;
                    settle_cnt <= settle_next;
                    // Settling is checked first so it wins over a coincident timeout.
                    if (settle_next == SETTLE_DONE) begin
                        state        <= HOLD;
                        heater_on    <= 1'b0;
                        temp_reached <= 1'b1;
                    end else if (timer_next == TIMER_LIMIT) begin
                        state      <= FAULT;
                        heater_on  <= 1'b0;
                        heat_fault <= 1'b1;
                    end
                end

                HOLD: begin
                    if (temp_valid) begin
                        if (below_band) begin
                            heater_on <= 1'b1;
                        end else if (at_target) begin
                            heater_on <= 1'b0;
                        end
                    end
                end

                FAULT: begin
                    heater_on <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_heater_controller.sv
// Self-checking bench for water_heater_controller: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a behavioural model.
module tb_water_heater_controller;

    localparam int TEMP_W  = 6;
    localparam int HYST    = 2;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [TEMP_W-1:0] selected_temperature = '0;
    logic [TEMP_W-1:0] water_temp = '0;
    logic              temp_valid = 1'b0;
    logic              heater_on;
    logic              temp_reached;
    logic              heat_fault;
    logic              busy;

    int total = 0;
    int bad   = 0;

    water_heater_controller #(
        .TEMP_W(TEMP_W),
        .HYST(HYST),
        .SETTLE_SAMPLES(SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .selected_temperature(selected_temperature),
        .water_temp(water_temp),
        .temp_valid(temp_valid),
        .heater_on(heater_on),
        .temp_reached(temp_reached),
        .heat_fault(heat_fault),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {heater,reached,fault,busy}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: activity mode, elapsed heating time and run of good samples.
    int m_mode = 0;  // 0 idle, 1 heating, 2 holding, 3 faulted
    int m_target = 0;
    int m_elapsed = 0;
    int m_consec = 0;
    bit m_heater = 0;
    bit model_live = 0;

    always @(posedge clk) begin
        if (reset || abort) begin
            m_mode = 0;
            m_heater = 0;
            m_target = 0;
            m_elapsed = 0;
            m_consec = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_target  = int'(selected_temperature);
                m_elapsed = 0;
                m_consec  = 0;
                m_mode    = (m_target == 0) ? 2 : 1;
                m_heater  = (m_target != 0);
            end
        end else if (m_mode == 1) begin
            m_elapsed = m_elapsed + 1;
            if (temp_valid) m_consec = (int'(water_temp) >= m_target) ? m_consec + 1 : 0;
            if (m_consec >= SETTLE) begin
                m_mode = 2;
                m_heater = 0;
            end else if (m_elapsed >= TIMEOUT) begin
                m_mode = 3;
                m_heater = 0;
            end
        end else if (m_mode == 2) begin
            if (temp_valid) begin
                if (int'(water_temp) + HYST < m_target) m_heater = 1;
                else if (int'(water_temp) >= m_target) m_heater = 0;
            end
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model", {heater_on, temp_reached, heat_fault, busy},
                  {m_heater, m_mode == 2, m_mode == 3, m_mode != 0});
        end
    end

    task automatic cyc(input logic rst, input logic st, input logic ab,
                       input logic [TEMP_W-1:0] sel, input logic [TEMP_W-1:0] wt, input logic vld);
        @(negedge clk);
        #1;
        reset = rst;
        start = st;
        abort = ab;
        selected_temperature = sel;
        water_temp = wt;
        temp_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] exp);
        check(name, {heater_on, temp_reached, heat_fault, busy}, exp);
    endtask

    initial begin
        // 1. Reset holds everything low even with start asserted.
        cyc(1, 1, 0, 40, 0, 0);
        cyc(1, 1, 0, 40, 0, 0);
        expect_out("reset_with_start", 4'b0000);
        cyc(0, 1, 0, 40, 0, 0);
        expect_out("reset_enter_heat", 4'b1001);
        cyc(1, 0, 0, 40, 0, 0);
        expect_out("reset_mid_heat", 4'b0000);

        // 2. Normal heat; the 39 sample breaks the settle run.
        cyc(0, 1, 0, 40, 0, 0);
        expect_out("heat_start", 4'b1001);
        cyc(0, 0, 0, 60, 20, 1);
        cyc(0, 0, 0, 60, 40, 1);
        cyc(0, 0, 0, 60, 39, 1);
        cyc(0, 0, 0, 60, 40, 1);
        expect_out("settle_restarted", 4'b1001);
        cyc(0, 0, 0, 60, 41, 1);
        expect_out("settled", 4'b0101);

        // 3. Hysteresis around target 40; a stray start must not relatch.
        cyc(0, 0, 0, 60, 38, 1);
        expect_out("hold_38", 4'b0101);
        cyc(0, 0, 0, 60, 37, 1);
        expect_out("hold_37", 4'b1101);
        cyc(0, 0, 0, 60, 39, 1);
        expect_out("hold_39", 4'b1101);
        cyc(0, 0, 0, 60, 40, 1);
        expect_out("hold_40", 4'b0101);
        cyc(0, 1, 0, 10, 40, 1);
        expect_out("hold_start_ignored", 4'b0101);
        cyc(0, 0, 0, 10, 37, 1);
        expect_out("hold_target_kept", 4'b1101);
        cyc(0, 0, 1, 10, 37, 1);
        expect_out("hold_abort", 4'b0000);

        // 4. Cold wash never heats.
        cyc(0, 1, 0, 0, 50, 1);
        expect_out("cold_start", 4'b0101);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, TEMP_W'($urandom_range(0, 63)), 1);
            expect_out("cold_hold", 4'b0101);
        end
        cyc(0, 0, 1, 0, 0, 0);

        // 5. Timeout after exactly TIMEOUT cycles in HEAT.
        cyc(0, 1, 0, 60, 30, 1);
        expect_out("timeout_start", 4'b1001);
        for (int i = 1; i < TIMEOUT; i++) cyc(0, 0, 0, 60, 30, 1);
        expect_out("timeout_minus_1", 4'b1001);
        cyc(0, 0, 0, 60, 30, 1);
        expect_out("timeout_fault", 4'b0011);
        cyc(0, 1, 0, 40, 50, 1);
        expect_out("fault_start_ignored", 4'b0011);
        cyc(0, 0, 1, 40, 50, 1);
        expect_out("fault_abort", 4'b0000);

        // 6. Priorities.
        cyc(0, 1, 1, 40, 0, 0);
        expect_out("start_abort_same", 4'b0000);
        cyc(0, 1, 0, 40, 0, 0);
        cyc(0, 0, 1, 40, 0, 0);
        expect_out("abort_heat", 4'b0000);
        cyc(0, 1, 0, 40, 0, 0);
        for (int i = 1; i <= TIMEOUT - 2; i++) cyc(0, 0, 0, 40, 30, 1);
        cyc(0, 0, 0, 40, 45, 1);
        expect_out("pre_timeout_settle", 4'b1001);
        cyc(0, 0, 0, 40, 45, 1);
        expect_out("settle_beats_timeout", 4'b0101);
        cyc(0, 0, 1, 40, 0, 0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [TEMP_W-1:0] sel;
            sel = ($urandom_range(0, 3) == 0) ? TEMP_W'($urandom_range(0, 3))
                                              : TEMP_W'($urandom_range(20, 63));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 59) == 0, sel,
                TEMP_W'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
